// File: rtl/histogram_decompressor_if.sv
// rtl/histogram_decompressor_if.sv - count-load and regenerated-stream bundle for histogram_decompressor
interface histogram_decompressor_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic [COUNTER_WIDTH-1:0] count_00;
  logic [COUNTER_WIDTH-1:0] count_01;
  logic [COUNTER_WIDTH-1:0] count_10;
  logic [COUNTER_WIDTH-1:0] count_11;
  logic                     load;
  logic                     load_ready;
  logic                     stream_a;
  logic                     stream_b;
  logic                     valid_out;
  logic                     out_ready;
  logic                     decompress_done;
  logic                     count_err;

  modport master (
    input  count_00, count_01, count_10, count_11, load, out_ready,
    output load_ready, stream_a, stream_b, valid_out, decompress_done, count_err
  );

  modport slave (
    output count_00, count_01, count_10, count_11, load, out_ready,
    input  load_ready, stream_a, stream_b, valid_out, decompress_done, count_err
  );
endinterface

// File: rtl/histogram_decompressor.sv
// rtl/histogram_decompressor.sv - regenerates a canonical-order unary stream pair from four joint-bin counts
module histogram_decompressor #(
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  histogram_decompressor_if.master bus
);
  localparam int SW = COUNTER_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                        state_q, state_d;
  logic [3:0][COUNTER_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]                    bin_q, bin_d;
  logic [COUNTER_WIDTH-1:0]      beat_q, beat_d;
  logic                          valid_q, valid_d;
  logic                          a_q, a_d;
  logic                          b_q, b_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;

  logic [3:0][COUNTER_WIDTH-1:0] load_counts;
  logic [SW-1:0]                 load_sum;
  logic                          load_acc;
  logic                          sum_ok;
  logic                          last_beat;

  // Lowest bin index >= start with a nonzero count; bins are emitted 00,01,10,11.
  function automatic logic [1:0] first_nonzero(input logic [3:0][COUNTER_WIDTH-1:0] cnt,
                                               input int start);
    logic [1:0] first;
    first = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (i >= start && cnt[i] != '0) first = 2'(i);
    end
    return first;
  endfunction

  assign load_counts = {bus.count_11, bus.count_10, bus.count_01, bus.count_00};
  // Full-width sum so that e.g. 128+128+128 cannot alias back to STREAM_LENGTH.
  assign load_sum    = SW'(bus.count_00) + SW'(bus.count_01) + SW'(bus.count_10) + SW'(bus.count_11);
  assign sum_ok      = (load_sum == SW'(STREAM_LENGTH));
  assign load_acc    = bus.load && (state_q == IDLE);
  assign last_beat   = (beat_q == COUNTER_WIDTH'(STREAM_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bin_q   <= 2'd0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bin_q   <= bin_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_acc && sum_ok) state_d = EMIT;
      EMIT:    if (bus.out_ready && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d   = rem_q;
    bin_d   = bin_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_acc) begin
          if (sum_ok) begin
            rem_d      = load_counts;
            bin_d      = first_nonzero(load_counts, 0);
            beat_d     = '0;
            valid_d    = 1'b1;
            {a_d, b_d} = first_nonzero(load_counts, 0);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          rem_d[bin_q] = rem_q[bin_q] - COUNTER_WIDTH'(1);
          beat_d       = beat_q + COUNTER_WIDTH'(1);
          if (last_beat) begin
            valid_d    = 1'b0;
            bin_d      = 2'd0;
            {a_d, b_d} = 2'b00;
          end else if (rem_q[bin_q] == COUNTER_WIDTH'(1)) begin
            // Bin exhausted: hop straight to the next populated bin, no bubble.
            bin_d      = first_nonzero(rem_q, int'(bin_q) + 1);
            {a_d, b_d} = first_nonzero(rem_q, int'(bin_q) + 1);
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.load_ready      = (state_q == IDLE);
  assign bus.stream_a        = a_q;
  assign bus.stream_b        = b_q;
  assign bus.valid_out       = valid_q;
  assign bus.decompress_done = done_q;
  assign bus.count_err       = err_q;
endmodule

// File: doc/histogram_decompressor.md
Name: histogram_decompressor

Overview:
- Inverse of the histogram compressor: takes the four joint-bin counts (00, 01, 10, 11) for a pair of unary bitstreams.
- Regenerates a stream pair (stream_a, stream_b) of exactly STREAM_LENGTH beats whose joint histogram equals the loaded counts.
- Sits on the decompression side of the unary-compression path; output feeds unary consumers or a loopback compressor for checking.
- Bit order is canonical, not original: all 00 pairs first, then 01, then 10, then 11.

Parameters:
STREAM_LENGTH, 128, beats per regenerated stream pair
COUNTER_WIDTH, $clog2(STREAM_LENGTH+1), width of each bin count

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
count_00  input  COUNTER_WIDTH  pairs with a=0,b=0
count_01  input  COUNTER_WIDTH  pairs with a=0,b=1
count_10  input  COUNTER_WIDTH  pairs with a=1,b=0
count_11  input  COUNTER_WIDTH  pairs with a=1,b=1
load  input  1  request to accept the count set this cycle
load_ready  output  1  high only in IDLE; load accepted when load && load_ready
stream_a  output  1  regenerated stream A bit
stream_b  output  1  regenerated stream B bit
valid_out  output  1  stream_a/stream_b hold a valid beat
out_ready  input  1  downstream accepts beat when valid_out && out_ready
decompress_done  output  1  one-cycle pulse after final beat accepted
count_err  output  1  one-cycle pulse when a load is rejected for bad sum

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; load_ready=1 in the following cycle.
  - stream_a=0, stream_b=0, valid_out=0, decompress_done=0, count_err=0.
  - All internal bin counters and the beat counter cleared.
  - Reset mid-stream aborts immediately; no further beats; remaining counts discarded.
- Output registers: all outputs registered except load_ready, which decodes state==IDLE.
- States: IDLE, EMIT, DONE.
- IDLE, on load accepted:
  - Sum the four counts in COUNTER_WIDTH+2 bits.
  - If sum != STREAM_LENGTH: pulse count_err for one cycle, stay in IDLE, latch nothing.
  - If sum == STREAM_LENGTH: latch the counts into remaining-bin registers, select the first bin with a nonzero count in order 00,01,10,11, go to EMIT. valid_out rises the next cycle (latency 1).
- EMIT:
  - valid_out=1; {stream_a,stream_b} = code of the current bin (00→0,0; 01→0,1; 10→1,0; 11→1,1).
  - Beat accepted (out_ready=1): decrement the current bin's remaining count and increment the beat counter.
    - If that bin reaches 0, advance to the next nonzero bin in the same cycle, skipping zero bins. There are no idle cycles between bins.
  - out_ready=0: outputs hold stable, no counter change.
  - After beat STREAM_LENGTH is accepted: valid_out=0 next cycle, go to DONE.
- DONE: decompress_done=1 for exactly one cycle, then IDLE.
- load while not IDLE: ignored (load_ready=0); inputs need not be held after acceptance.
- Counts of 0 in every bin but one are legal; e.g. 128,0,0,0 emits 128 beats of 00.
- Sum check uses the full-width sum, so overflow never aliases to STREAM_LENGTH.
- Beat counter width is COUNTER_WIDTH; it never wraps because of the sum check.
- Throughput: one beat per cycle with out_ready tied high. Load to decompress_done = STREAM_LENGTH+2 cycles.

Test Plan:
- Reset, load 128/0/0/0, out_ready=1:
  - valid_out rises 1 cycle after load.
  - Exactly 128 beats of a=0,b=0.
  - decompress_done pulses once, 1 cycle after valid_out falls; load_ready returns to 1.
- Load 32/32/32/32, out_ready=1 → beats 0-31 = 00, 32-63 = 01, 64-95 = 10, 96-127 = 11; no gap cycles at bin boundaries.
- Load 0/5/0/123, with out_ready toggled pseudo-randomly:
  - Outputs stable while stalled.
  - Exactly 5 beats of 01, then 123 of 11.
  - Total accepted beats = 128.
- Load 10/10/10/10 (sum 40) → count_err single pulse, valid_out stays 0, load_ready stays 1. Then load 100/28/0/0 → accepted normally.
- Assert rst at beat 60 of a 64/0/0/64 run → next cycle valid_out=0, load_ready=1, no decompress_done. A following 0/0/128/0 load emits 128 beats of 10.
- Loopback, 5 random streams (seed 12345+j*100): compressor counts feed this block, whose output feeds a second compressor → second compressor's counts equal the first's exactly.
